// File: rtl/dma_bus_master_pkg.sv
// Shared definitions for the DMA bus-cycle initiator.
package dma_bus_master_pkg;

  // Bus-master sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OWN,
    S_ADDR,
    S_STRB,
    S_WAIT,
    S_END,
    S_HOLD
  } state_t;

  // DMADIR value that selects a memory read (RW=1).
  localparam logic DIR_READ = 1'b1;

  // DSACK_ code of a 32-bit port acknowledge.
  localparam logic [1:0] DSACK_32 = 2'b00;

  // Longword alignment: the two low address bits are never driven.
  function automatic logic [31:0] lw_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter shared by the WAIT termination timeout and the HOLD idle timeout.
// o_tc marks the TIMEOUT-th consecutive enabled cycle, so the owner leaves on
// the edge that completes TIMEOUT cycles in the state.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  // Count enabled cycles, saturating at terminal count; clear wins over count.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)       r_cnt <= '0;
    else if (i_en && !o_tc)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/dma_bus_master.sv
// 68030 bus-cycle initiator: arbitrates for the bus and runs single longword
// read/write cycles for the DMA/FIFO path, holding the bus between chained
// transfers until LAST or an error.
module dma_bus_master
  import dma_bus_master_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int DSACK_W = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_dmadir,
  input  logic [31:0]        i_addr_in,
  input  logic [31:0]        i_wdata,
  input  logic               i_last,
  output logic               o_br_n,
  input  logic               i_bg_n,
  output logic               o_bgack_n,
  output logic [31:0]        o_a,
  output logic               o_rw,
  output logic               o_as_n,
  output logic               o_ds_n,
  output logic [31:0]        o_d_out,
  output logic               o_d_oe,
  input  logic [31:0]        i_d_in,
  input  logic               i_sterm_n,
  input  logic [DSACK_W-1:0] i_dsack_n,
  input  logic               i_berr_n,
  output logic [31:0]        o_rdata,
  output logic               o_done,
  output logic               o_err,
  output logic               o_busy
);

  state_t      r_state, w_next;
  logic        r_dir, r_last, r_ok;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_take, w_term, w_ok, w_tc, w_cnt_run;

  // START is only honoured when no cycle is in flight.
  assign w_take    = i_start && ((r_state == S_IDLE) || (r_state == S_HOLD));
  assign w_cnt_run = (r_state == S_WAIT) || (r_state == S_HOLD);

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (!w_cnt_run),
    .i_en  (w_cnt_run),
    .o_tc  (w_tc)
  );

  // Termination decode for WAIT: bus error beats any acknowledge; sized
  // (8/16-bit) DSACK_ is an error since only 32-bit ports are supported.
  always_comb begin
    w_term = 1'b0;
    w_ok   = 1'b0;
    if (!i_berr_n) begin
      w_term = 1'b1;
    end else if (!i_sterm_n || (i_dsack_n == DSACK_W'(DSACK_32))) begin
      w_term = 1'b1;
      w_ok   = 1'b1;
    end else if (i_dsack_n != '1) begin
      w_term = 1'b1;
    end else if (w_tc) begin
      w_term = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and bus strobes; DS_ trails AS_ by one cycle on writes so the
  // data bus has settled before the slave samples it.
  always_comb begin
    w_next    = r_state;
    o_br_n    = 1'b1;
    o_bgack_n = 1'b1;
    o_as_n    = 1'b1;
    o_ds_n    = 1'b1;
    o_rw      = 1'b1;
    o_d_oe    = 1'b0;
    o_done    = 1'b0;
    o_err     = 1'b0;
    case (r_state)
      S_IDLE: if (w_take) w_next = S_REQ;
      S_REQ: begin
        o_br_n = 1'b0;
        if (!i_bg_n) w_next = S_OWN;
      end
      S_OWN: begin
        o_bgack_n = 1'b0;
        w_next    = S_ADDR;
      end
      S_ADDR: begin
        o_bgack_n = 1'b0;
        o_rw      = r_dir;
        o_d_oe    = (r_dir != DIR_READ);
        w_next    = S_STRB;
      end
      S_STRB: begin
        o_bgack_n = 1'b0;
        o_rw      = r_dir;
        o_d_oe    = (r_dir != DIR_READ);
        o_as_n    = 1'b0;
        o_ds_n    = (r_dir != DIR_READ);
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        o_bgack_n = 1'b0;
        o_rw      = r_dir;
        o_d_oe    = (r_dir != DIR_READ);
        o_as_n    = 1'b0;
        o_ds_n    = 1'b0;
        if (w_term) w_next = S_END;
      end
      S_END: begin
        o_bgack_n = 1'b0;
        o_rw      = r_dir;
        o_done    = r_ok;
        o_err     = !r_ok;
        w_next    = (r_last || !r_ok) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        o_bgack_n = 1'b0;
        if (w_take)    w_next = S_ADDR;
        else if (w_tc) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer parameters latched on START, result captured on the terminating edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dir   <= DIR_READ;
      r_last  <= 1'b0;
      r_ok    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_dir   <= i_dmadir;
        r_last  <= i_last;
        r_addr  <= lw_align(i_addr_in);
        r_wdata <= i_wdata;
      end
      if ((r_state == S_WAIT) && w_term) begin
        r_ok <= w_ok;
        if (r_dir == DIR_READ) r_rdata <= i_d_in;
      end
    end
  end

  assign o_a     = r_addr;
  assign o_d_out = r_wdata;
  assign o_rdata = r_rdata;
  assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master: a per-cycle timeline of stimulus and expected
// outputs is planned from transaction descriptions, then driven and compared.
module tb_dma_bus_master;

  localparam int TO = 20;
  localparam int N  = 190;
  localparam int P_REQ = 0, P_OWN = 1, P_ADDR = 2, P_STRB = 3, P_WAIT = 4, P_END = 5, P_HOLD = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, dir, last, bg_n, sterm_n, berr_n;
  logic [1:0]  dsack_n;
  logic [31:0] addr_in, wdata, d_in;
  logic        br_n, bgack_n, rw, as_n, ds_n, d_oe, done, err, busy;
  logic [31:0] a, d_out, rdata;

  dma_bus_master #(.TIMEOUT(TO), .DSACK_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dmadir(dir), .i_addr_in(addr_in),
    .i_wdata(wdata), .i_last(last), .o_br_n(br_n), .i_bg_n(bg_n), .o_bgack_n(bgack_n),
    .o_a(a), .o_rw(rw), .o_as_n(as_n), .o_ds_n(ds_n), .o_d_out(d_out), .o_d_oe(d_oe),
    .i_d_in(d_in), .i_sterm_n(sterm_n), .i_dsack_n(dsack_n), .i_berr_n(berr_n),
    .o_rdata(rdata), .o_done(done), .o_err(err), .o_busy(busy)
  );

  typedef struct {
    logic brn, bgk, rw, asn, dsn, oe, done, err, busy;
    logic ca, cd, cr;
    logic [31:0] a, dout, rdata;
  } exp_t;

  // Stimulus per cycle (applied during cycle c, sampled at the edge ending it).
  logic        s_rst[N], s_start[N], s_dir[N], s_last[N], s_bg[N], s_sterm[N], s_berr[N];
  logic [1:0]  s_dsack[N];
  logic [31:0] s_addr[N], s_wd[N], s_din[N];
  exp_t        ex[N];

  int n_chk = 0, n_err = 0;
  int done_q[$], err_q[$];
  logic [31:0] rd_q[$];
  int br_falls = 0;

  function automatic exp_t idle_x();
    exp_t x;
    x.brn = 1; x.bgk = 1; x.rw = 1; x.asn = 1; x.dsn = 1; x.oe = 0;
    x.done = 0; x.err = 0; x.busy = 0; x.ca = 0; x.cd = 0; x.cr = 0;
    x.a = '0; x.dout = '0; x.rdata = '0;
    return x;
  endfunction

  function automatic exp_t rst_x();
    exp_t x;
    x = idle_x();
    x.ca = 1; x.cd = 1; x.cr = 1;
    return x;
  endfunction

  // Output rules per bus phase.
  function automatic exp_t bus_x(int ph, logic d, logic [31:0] aa, logic [31:0] wd);
    exp_t x;
    x = idle_x();
    x.busy = 1;
    if (ph == P_REQ) x.brn = 0;
    else if (ph == P_OWN || ph == P_HOLD) x.bgk = 0;
    else begin
      x.bgk  = 0;
      x.rw   = d;
      x.ca   = 1;
      x.a    = aa;
      x.oe   = (ph != P_END) && !d;
      x.cd   = x.oe;
      x.dout = wd;
      x.asn  = !(ph == P_STRB || ph == P_WAIT);
      x.dsn  = !(ph == P_WAIT || (ph == P_STRB && d));
    end
    return x;
  endfunction

  // term: 0 STERM_, 1 DSACK_=00, 2 BERR_, 3 BERR_+STERM_, 4 DSACK_=01, 5 none (timeout)
  task automatic plan(input int t, input bit fh, input logic d, input logic [31:0] ad,
                      input logic [31:0] wd, input int g, input int w, input int term,
                      input logic [31:0] din, input bit lst);
    int base, e, tc;
    logic ok;
    logic [31:0] aa;
    aa = {ad[31:2], 2'b00};
    s_start[t] = 1; s_dir[t] = d; s_addr[t] = ad; s_wd[t] = wd; s_last[t] = lst;
    if (fh) base = t + 1;
    else begin
      for (int c = t + 1; c <= t + 1 + g; c++) ex[c] = bus_x(P_REQ, d, aa, wd);
      ex[t + 2 + g] = bus_x(P_OWN, d, aa, wd);
      base = t + 3 + g;
      for (int c = t + 1 + g; c <= base + 3 + w; c++) s_bg[c] = 0;
    end
    e  = base + 3 + w;
    tc = base + 2 + w;
    ex[base]     = bus_x(P_ADDR, d, aa, wd);
    ex[base + 1] = bus_x(P_STRB, d, aa, wd);
    for (int c = base + 2; c <= tc; c++) ex[c] = bus_x(P_WAIT, d, aa, wd);
    ex[e] = bus_x(P_END, d, aa, wd);
    case (term)
      0: s_sterm[tc] = 0;
      1: s_dsack[tc] = 2'b00;
      2: s_berr[tc] = 0;
      3: begin s_berr[tc] = 0; s_sterm[tc] = 0; end
      4: s_dsack[tc] = 2'b01;
      default: ;
    endcase
    s_din[tc] = din;
    ok = (term < 2);
    ex[e].done = ok;
    ex[e].err  = !ok;
    if (ok && d) begin ex[e].cr = 1; ex[e].rdata = din; end
    if (lst || !ok) begin
      for (int c = e + 1; c <= e + TO + 1 && c < N; c++) ex[c] = idle_x();
    end else begin
      for (int c = e + 1; c <= e + TO && c < N; c++) ex[c] = bus_x(P_HOLD, d, aa, wd);
      if (e + TO + 1 < N) ex[e + TO + 1] = idle_x();
    end
  endtask

  task automatic apply(input int c);
    rst = s_rst[c]; start = s_start[c]; dir = s_dir[c]; last = s_last[c];
    addr_in = s_addr[c]; wdata = s_wd[c]; bg_n = s_bg[c]; sterm_n = s_sterm[c];
    berr_n = s_berr[c]; dsack_n = s_dsack[c]; d_in = s_din[c];
  endtask

  task automatic chk1(input string nm, input int c, input logic act, input logic exv);
    n_chk++;
    if (act !== exv) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, act, exv);
    end
  endtask

  task automatic chk32(input string nm, input int c, input logic [31:0] act, input logic [31:0] exv);
    n_chk++;
    if (act !== exv) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exv);
    end
  endtask

  // Build the timeline, then drive it.
  initial begin
    for (int c = 0; c < N; c++) begin
      s_rst[c] = 0; s_start[c] = 0; s_dir[c] = 1; s_last[c] = 0; s_bg[c] = 1;
      s_sterm[c] = 1; s_berr[c] = 1; s_dsack[c] = 2'b11;
      s_addr[c] = '0; s_wd[c] = '0; s_din[c] = '0;
      ex[c] = idle_x();
    end
    s_rst[0] = 1; s_rst[1] = 1;
    for (int c = 1; c <= 5; c++) ex[c] = rst_x();
    // read, grant late, zero-wait STERM_
    plan(5,   0, 1, 32'h0000_2000, 32'h0,          3, 0,      0, 32'hDEADBEEF, 1);
    // write, misaligned address, DSACK_ after 2 waits
    plan(20,  0, 0, 32'h0000_1003, 32'h1234_5678,  0, 2,      1, 32'h0,        1);
    // three chained writes
    plan(35,  0, 0, 32'h0000_4000, 32'hA5A5_0001,  0, 0,      0, 32'h0,        0);
    plan(43,  1, 0, 32'h0000_4004, 32'hA5A5_0002,  0, 0,      0, 32'h0,        0);
    plan(48,  1, 0, 32'h0000_4008, 32'hA5A5_0003,  0, 0,      0, 32'h0,        1);
    s_start[39] = 1; s_addr[39] = 32'hFFFF_FFF0; s_wd[39] = 32'h0BAD_0BAD; s_last[39] = 1;
    // BERR_ together with STERM_, grant withdrawn while owning
    plan(60,  0, 1, 32'h0000_5000, 32'h0,          0, 1,      3, 32'h1111_2222, 0);
    for (int c = 64; c <= 67; c++) s_bg[c] = 1;
    // no termination
    plan(75,  0, 0, 32'h0000_6000, 32'hCAFE_F00D,  0, TO - 1, 5, 32'h0,        1);
    // 16-bit acknowledge
    plan(110, 0, 1, 32'h0000_7000, 32'h0,          1, 0,      4, 32'h3333_4444, 1);
    // single write left in HOLD until the idle timeout
    plan(125, 0, 0, 32'h0000_8000, 32'h5555_AAAA,  0, 0,      0, 32'h0,        0);
    // read interrupted by reset in WAIT
    plan(160, 0, 1, 32'h0000_9000, 32'h0,          0, 5,      0, 32'h7777_8888, 1);
    s_rst[166] = 1;
    for (int c = 167; c < N; c++) ex[c] = rst_x();

    apply(0);
    for (int c = 1; c < N; c++) begin
      @(posedge clk);
      #1;
      apply(c);
    end
  end

  // Compare every cycle at the falling edge.
  initial begin
    static int exp_done[6] = '{14, 28, 41, 47, 52, 131};
    static int exp_err[3]  = '{67, 100, 117};
    logic prev_br;
    exp_t x;
    prev_br = 1'b1;
    for (int c = 1; c < N; c++) begin
      @(posedge clk);
      @(negedge clk);
      x = ex[c];
      chk1("BR_", c, br_n, x.brn);
      chk1("BGACK_", c, bgack_n, x.bgk);
      chk1("RW", c, rw, x.rw);
      chk1("AS_", c, as_n, x.asn);
      chk1("DS_", c, ds_n, x.dsn);
      chk1("D_OE", c, d_oe, x.oe);
      chk1("DONE", c, done, x.done);
      chk1("ERR", c, err, x.err);
      chk1("BUSY", c, busy, x.busy);
      if (x.ca) chk32("A", c, a, x.a);
      if (x.cd) chk32("D_OUT", c, d_out, x.dout);
      if (x.cr) chk32("RDATA", c, rdata, x.rdata);
      if (c == 23)  chk32("A_aligned", c, a, 32'h0000_1000);
      if (c == 24)  chk1("DS_late", c, ds_n, 1'b1);
      if (c == 151) chk1("hold_last", c, bgack_n, 1'b0);
      if (c == 152) chk1("hold_release", c, busy, 1'b0);
      if (prev_br === 1'b1 && br_n === 1'b0) br_falls++;
      prev_br = br_n;
      if (done === 1'b1) begin done_q.push_back(c); rd_q.push_back(rdata); end
      if (err === 1'b1) err_q.push_back(c);
    end
    chk32("n_done", 0, done_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < done_q.size()) chk32("done_cyc", i, done_q[i], exp_done[i]);
    chk32("n_err", 0, err_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < err_q.size()) chk32("err_cyc", i, err_q[i], exp_err[i]);
    if (rd_q.size() > 0) chk32("rdata_first", 0, rd_q[0], 32'hDEADBEEF);
    chk32("br_requests", 0, br_falls, 8);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
